// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared channel state encoding, reset period and cfg decode helper
package tick_gen_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
  localparam logic [31:0] DEFAULT_PERIOD = 32'h01F78A40;
  function automatic logic cfg_hit(input logic we, input logic [3:0] ch, input int unsigned idx);
    return we && (ch == idx[3:0]);
  endfunction
endpackage

// File: rtl/tick_chan.sv
// tick_chan: one tick channel (IDLE/RUN/DONE state, counter, period register, registered tick)
// Ports: clk, reset (sync, active-high), start_i run enable, clr_i sync clear to IDLE,
//        mode_i 0 periodic / 1 one-shot, we_i/period_i period load, tick_o expiry pulse,
//        busy_o high in RUN, count_o live counter.
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int unsigned       CNT_W      = 32,
  parameter logic [CNT_W-1:0]  RST_PERIOD = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             clr_i,
  input  logic             mode_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             tick_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] count_o
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic             tick_q, tick_d, mode_q, mode_d;
  logic             expire;
  // >= rather than == so a period shrunk below the live count expires at once
  assign expire   = cnt_q >= period_q;
  // the compare above sees period_q, so a write on the same edge only affects later cycles
  assign period_d = we_i ? period_i : period_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    mode_d  = mode_q;
    if (clr_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: if (start_i) begin
          state_d = RUN;
          cnt_d   = '0;
          mode_d  = mode_i;
        end
        RUN: if (start_i) begin
          cnt_d   = expire ? '0 : cnt_q + 1'b1;
          tick_d  = expire;
          state_d = (expire && mode_q) ? DONE : RUN;
        end
        DONE: begin
          cnt_d   = '0;
          state_d = start_i ? DONE : IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      mode_q   <= 1'b0;
      period_q <= RST_PERIOD;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      mode_q   <= mode_d;
      period_q <= period_d;
    end
  end
  assign tick_o  = tick_q;
  assign busy_o  = state_q == RUN;
  assign count_o = cnt_q;
endmodule

// File: rtl/multi_tick_gen.sv
// multi_tick_gen: NUM_CH independent programmable tick generators with shared period write port
// Ports: clk, reset (sync, active-high), start/clr/mode per channel, cfg_we/cfg_ch/cfg_period
//        period write, tick/busy per channel, count packed as channel i at [i*CNT_W +: CNT_W].
// Build option MULTI_TICK_GEN_IRQ_EN adds irq_flag (sticky, set by tick) and irq_clr.
module multi_tick_gen #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CNT_W          = 32,
  parameter logic [31:0] DEFAULT_PERIOD = tick_gen_pkg::DEFAULT_PERIOD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       clr,
  input  logic [NUM_CH-1:0]       mode,
  input  logic                    cfg_we,
  input  logic [3:0]              cfg_ch,
  input  logic [CNT_W-1:0]        cfg_period,
`ifdef MULTI_TICK_GEN_IRQ_EN
  output logic [NUM_CH-1:0]       irq_flag,
  input  logic [NUM_CH-1:0]       irq_clr,
`endif
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH*CNT_W-1:0] count
);
  import tick_gen_pkg::*;
  // channel indices >= NUM_CH match no instance, so such writes fall away
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_chan #(
      .CNT_W      (CNT_W),
      .RST_PERIOD (CNT_W'(DEFAULT_PERIOD))
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .start_i  (start[i]),
      .clr_i    (clr[i]),
      .mode_i   (mode[i]),
      .we_i     (cfg_hit(cfg_we, cfg_ch, i)),
      .period_i (cfg_period),
      .tick_o   (tick[i]),
      .busy_o   (busy[i]),
      .count_o  (count[i*CNT_W +: CNT_W])
    );
  end
`ifdef MULTI_TICK_GEN_IRQ_EN
  logic [NUM_CH-1:0] irq_q, irq_d;
  // set wins over a coincident clear
  assign irq_d = (irq_q & ~irq_clr) | tick;
  always_ff @(posedge clk) begin
    if (reset) irq_q <= '0;
    else       irq_q <= irq_d;
  end
  assign irq_flag = irq_q;
`endif
endmodule

// File: tb/tb_multi_tick_gen.sv
// tb_multi_tick_gen: directed self-checking bench for multi_tick_gen
module tb_multi_tick_gen;
  localparam int NC = 4;
  localparam int CW = 32;
  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] start, clr, mode;
  logic          cfg_we;
  logic [3:0]    cfg_ch;
  logic [CW-1:0] cfg_period;
  logic [NC-1:0] tick, busy;
  logic [NC*CW-1:0] count;
`ifdef MULTI_TICK_GEN_IRQ_EN
  logic [NC-1:0] irq_flag, irq_clr;
`endif
  int n_chk = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  multi_tick_gen #(.NUM_CH(NC), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .clr        (clr),
    .mode       (mode),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
`ifdef MULTI_TICK_GEN_IRQ_EN
    .irq_flag   (irq_flag),
    .irq_clr    (irq_clr),
`endif
    .tick       (tick),
    .busy       (busy),
    .count      (count)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [3:0] ch, input logic [CW-1:0] p);
    cfg_we = 1'b1; cfg_ch = ch; cfg_period = p;
    step();
    cfg_we = 1'b0;
  endtask
  function automatic logic [CW-1:0] cnt(input int i);
    return count[i*CW +: CW];
  endfunction
  initial begin
    reset = 1'b1; start = '0; clr = '0; mode = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
`ifdef MULTI_TICK_GEN_IRQ_EN
    irq_clr = '0;
`endif
    step(2);
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_period", dut.g_ch[0].u_chan.period_q, 32'h01F78A40);
    reset = 1'b0;
    // periodic, period 3
    wr(0, 3);
    start[0] = 1'b1;
    step();
    chk("per_first", cnt(0), 0);
    chk("per_busy", busy[0], 1);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("per_cnt%0d", k), cnt(0), k % 4);
      chk($sformatf("per_tick%0d", k), tick[0], (k % 4) == 0);
    end
    start[0] = 1'b0; clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    // out-of-range channel write is ignored
    wr(4, 7);
    chk("cfg_oob", dut.g_ch[0].u_chan.period_q, 3);
    // one-shot, period 2
    wr(1, 2);
    start[1] = 1'b1; mode[1] = 1'b1;
    step();
    chk("os_c0", cnt(1), 0);
    step();
    chk("os_c1", cnt(1), 1);
    step();
    chk("os_c2", cnt(1), 2);
    chk("os_notick", tick[1], 0);
    step();
    chk("os_tick", tick[1], 1);
    chk("os_busy", busy[1], 0);
    chk("os_done_cnt", cnt(1), 0);
    step();
    chk("os_tick_once", tick[1], 0);
    chk("os_done_busy", busy[1], 0);
    start[1] = 1'b0;
    step();
    start[1] = 1'b1;
    step();
    chk("os_rerun_busy", busy[1], 1);
    chk("os_rerun_cnt", cnt(1), 0);
    step(3);
    chk("os_rerun_tick", tick[1], 1);
    chk("os_rerun_done", busy[1], 0);
    start[1] = 1'b0; mode[1] = 1'b0;
    step();
    // pause, period 10
    wr(2, 10);
    start[2] = 1'b1;
    step(6);
    chk("pz_cnt5", cnt(2), 5);
    start[2] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("pz_hold", cnt(2), 5);
      chk("pz_notick", tick[2], 0);
    end
    chk("pz_busy", busy[2], 1);
    start[2] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("pz_tick%0d", k), tick[2], k == 6);
    end
    chk("pz_wrap", cnt(2), 0);
    clr[2] = 1'b1; start[2] = 1'b0;
    step();
    clr[2] = 1'b0;
    // shrink period below live count
    wr(3, 20);
    start[3] = 1'b1;
    step(9);
    chk("sh_cnt8", cnt(3), 8);
    cfg_we = 1'b1; cfg_ch = 3; cfg_period = 4;
    step();
    cfg_we = 1'b0;
    chk("sh_old", cnt(3), 9);
    chk("sh_old_tick", tick[3], 0);
    step();
    chk("sh_tick", tick[3], 1);
    chk("sh_zero", cnt(3), 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("sh_tick%0d", k), tick[3], k == 5);
    end
    clr[3] = 1'b1; start[3] = 1'b0;
    step();
    clr[3] = 1'b0;
    // clr beats start, then reset mid-run
    start[0] = 1'b1;
    step(3);
    chk("cl_cnt2", cnt(0), 2);
    clr[0] = 1'b1;
    step();
    chk("cl_busy", busy[0], 0);
    chk("cl_cnt", cnt(0), 0);
    clr[0] = 1'b0;
    step();
    chk("cl_restart", busy[0], 1);
    step(3);
    chk("rr_cnt3", cnt(0), 3);
    reset = 1'b1;
    step();
    chk("rr_notick", tick[0], 0);
    chk("rr_busy", busy[0], 0);
    chk("rr_cnt", cnt(0), 0);
    chk("rr_period0", dut.g_ch[0].u_chan.period_q, 32'h01F78A40);
    chk("rr_period3", dut.g_ch[3].u_chan.period_q, 32'h01F78A40);
    start = '0;
    reset = 1'b0;
    // period 0 on every channel, all tick together every cycle
    for (int i = 0; i < NC; i++) wr(4'(i), 0);
    start = '1;
    step();
    chk("all_busy", busy, 4'hF);
    chk("all_first", tick, 0);
    step();
    chk("all_tick1", tick, 4'hF);
    step();
    chk("all_tick2", tick, 4'hF);
`ifdef MULTI_TICK_GEN_IRQ_EN
    chk("irq_set", irq_flag, 4'hF);
    irq_clr[0] = 1'b1;
    step();
    chk("irq_coinc", irq_flag[0], 1);
    irq_clr[0] = 1'b0; clr[0] = 1'b1;
    step();
    irq_clr[0] = 1'b1;
    step();
    chk("irq_clr", irq_flag[0], 0);
    chk("irq_others", irq_flag[3:1], 3'h7);
    irq_clr[0] = 1'b0; clr[0] = 1'b0;
`endif
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/multi_tick_gen.md
MULTI_TICK_GEN -- requirements
Module: multi_tick_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent tick channels (1..16).
REQ-002 Parameter CNT_W, default 32: counter and period width in bits.
REQ-003 Parameter DEFAULT_PERIOD, default 32'h01F78A40: reset value of every period register.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  NUM_CH  per-channel run enable; low while running = pause.
REQ-007 clr  input  NUM_CH  per-channel synchronous clear to IDLE.
REQ-008 mode  input  NUM_CH  per-channel mode: 0 periodic, 1 one-shot; sampled on IDLE->RUN.
REQ-009 cfg_we  input  1  period write strobe.
REQ-010 cfg_ch  input  4  channel index for the period write.
REQ-011 cfg_period  input  CNT_W  period value to write.
REQ-012 tick  output  NUM_CH  one-cycle registered pulse per expiry.
REQ-013 busy  output  NUM_CH  high while the channel is in RUN.
REQ-014 count  output  NUM_CH*CNT_W  live counters; channel i at bits [i*CNT_W +: CNT_W].

Function
REQ-015 Each channel SHALL implement states IDLE, RUN, DONE.
REQ-016 IDLE->RUN when start=1 and clr=0; the counter SHALL be 0 on the first RUN cycle and the mode SHALL be latched.
REQ-017 In RUN with start=1: if count >= period, count<=0 and tick<=1; else count<=count+1 and tick<=0.
REQ-018 Expiry interval SHALL be period+1 cycles; period 0 SHALL tick every cycle.
REQ-019 The >= comparison SHALL keep the counter from running past a newly written smaller period; there is no wrap-around.
REQ-020 In RUN with start=0, count SHALL hold, tick SHALL be 0, and the state SHALL stay RUN.
REQ-021 Periodic mode SHALL stay in RUN after expiry; one-shot mode SHALL go RUN->DONE on the expiry cycle.
REQ-022 DONE SHALL hold count at 0 with tick=0, and go DONE->IDLE when start=0.
REQ-023 clr=1 SHALL force IDLE with count<=0 and tick<=0 in any state; clr has priority over start.
REQ-024 cfg_we=1 SHALL load cfg_period into period[cfg_ch] at the edge; cfg_ch >= NUM_CH SHALL be ignored.
REQ-025 A period write coincident with a compare SHALL use the old period for that cycle.
REQ-026 Channels SHALL be fully independent; simultaneous ticks on all channels are legal.

Reset
REQ-027 reset SHALL set all states to IDLE, all counts to 0, tick=0, busy=0, and all periods to DEFAULT_PERIOD.
REQ-028 reset SHALL override clr, start and cfg_we; reset mid-RUN aborts with no tick issued.

Configuration
REQ-029 Macro MULTI_TICK_GEN_IRQ_EN defined: add port irq_flag output NUM_CH (sticky, set by tick) and port irq_clr input NUM_CH (clears its flag).
REQ-030 With MULTI_TICK_GEN_IRQ_EN: a set and a clear in the same cycle leave the flag at 1; reset clears all flags.
REQ-031 Without MULTI_TICK_GEN_IRQ_EN: irq_flag and irq_clr SHALL be absent and no flag logic synthesised.

Structure
REQ-032 Package tick_gen_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the DEFAULT_PERIOD constant.
REQ-033 Sub-module tick_chan SHALL implement one channel: state, counter, period and tick; the top generates NUM_CH instances plus the cfg decode and optional irq flags.

Verification
REQ-034 Period 3, periodic, start held -> tick at cycles 4, 8, 12 after start; count sequence 0,1,2,3,0.
REQ-035 Period 2, one-shot -> single tick on the 3rd RUN cycle, busy falls and DONE is reached; start low -> IDLE; start high again -> new run.
REQ-036 Period 10, start dropped at count 5 for 7 cycles -> count holds 5, no tick; on resume tick after 6 more cycles.
REQ-037 Count 8 with period 20, then write period 4 -> tick on the next cycle, then every 5 cycles.
REQ-038 clr and start asserted together in RUN -> IDLE, count 0; reset mid-RUN -> period reads back 32'h01F78A40.
REQ-039 With MULTI_TICK_GEN_IRQ_EN, tick and irq_clr coincident -> irq_flag stays 1; irq_clr alone -> 0.
